// File: rtl/gate_pkg.sv
// Shared definitions for the two-input gate exerciser and the gate benches:
// operation encodings, FSM state type and the vector count.
package gate_pkg;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    localparam int NUM_VECTORS = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_t;

endpackage

// File: rtl/gate_ref_model.sv
// Golden combinational model of the two-input gates: expected y for a given
// operation code and A/B inputs.
module gate_ref_model
    import gate_pkg::*;
(
    input  logic [1:0] op,
    input  logic       a,
    input  logic       b,
    output logic       y
);

    always_comb begin
        unique case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NAND: y = ~(a & b);
            default: y = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_exerciser.sv
// Drives a two-input gate through all four input vectors, samples Y after a
// settle window and records pass flag, mismatch count and per-vector fail mask.
module gate_exerciser
    import gate_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2  // legal range 1..15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] OP,
    output logic       A,
    output logic       B,
    input  logic       Y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_mask
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);
    localparam logic [1:0] LAST_IDX    = 2'(NUM_VECTORS - 1);

    state_t     state;
    state_t     state_next;
    logic [1:0] op_q;
    logic [1:0] idx;
    logic [3:0] cnt;
    logic       y_exp;
    logic       mismatch;
    logic [2:0] err_next;

    // Expected value uses the registered A/B, so it lines up with the Y they produce.
    gate_ref_model u_ref (
        .op (op_q),
        .a  (A),
        .b  (B),
        .y  (y_exp)
    );

    assign mismatch = (Y != y_exp);
    assign err_next = err_count + 3'(mismatch);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) state_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                busy = 1'b1;
                if (cnt == 4'd1) state_next = ST_CHECK;
            end
            ST_CHECK: begin
                busy       = 1'b1;
                state_next = (idx == LAST_IDX) ? ST_DONE : ST_SETTLE;
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= OP_AND;
            idx       <= 2'd0;
            cnt       <= 4'd0;
            A         <= 1'b0;
            B         <= 1'b0;
            pass      <= 1'b0;
            err_count <= 3'd0;
            fail_mask <= 4'd0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q      <= OP;
                        idx       <= 2'd0;
                        cnt       <= SETTLE_LOAD;
                        {A, B}    <= 2'b00;
                        pass      <= 1'b0;
                        err_count <= 3'd0;
                        fail_mask <= 4'd0;
                    end
                end
                ST_SETTLE: cnt <= cnt - 4'd1;
                ST_CHECK: begin
                    if (mismatch) fail_mask[idx] <= 1'b1;
                    err_count <= err_next;
                    if (idx != LAST_IDX) begin
                        idx    <= idx + 2'd1;
                        {A, B} <= idx + 2'd1;
                        cnt    <= SETTLE_LOAD;
                    end else begin
                        {A, B} <= 2'b00;
                        pass   <= (err_next == 3'd0);
                    end
                end
                ST_DONE: {A, B} <= 2'b00;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_exerciser.sv
// Scoreboard bench: three exercisers (SETTLE_CYCLES 1, 2, 4) run in lockstep
// against a bench-side OR gate or a stuck-at-0 output.
module tb_gate_exerciser;

    typedef struct packed {
        logic [1:0] id;
        logic       pass;
        logic [2:0] err;
        logic [3:0] mask;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] op_in = 2'b00;
    bit         tie0 = 1'b0;

    logic       a     [3];
    logic       b     [3];
    logic       y     [3];
    logic       busy  [3];
    logic       done  [3];
    logic       pass  [3];
    logic [2:0] err   [3];
    logic [3:0] mask  [3];

    int   settle_of [3] = '{1, 2, 4};
    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    assign y[0] = tie0 ? 1'b0 : (a[0] | b[0]);
    assign y[1] = tie0 ? 1'b0 : (a[1] | b[1]);
    assign y[2] = tie0 ? 1'b0 : (a[2] | b[2]);

    gate_exerciser #(.SETTLE_CYCLES(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .start(start), .OP(op_in),
        .A(a[0]), .B(b[0]), .Y(y[0]), .busy(busy[0]), .done(done[0]),
        .pass(pass[0]), .err_count(err[0]), .fail_mask(mask[0])
    );

    gate_exerciser u_s2 (
        .clk(clk), .rst_n(rst_n), .start(start), .OP(op_in),
        .A(a[1]), .B(b[1]), .Y(y[1]), .busy(busy[1]), .done(done[1]),
        .pass(pass[1]), .err_count(err[1]), .fail_mask(mask[1])
    );

    gate_exerciser #(.SETTLE_CYCLES(4)) u_s4 (
        .clk(clk), .rst_n(rst_n), .start(start), .OP(op_in),
        .A(a[2]), .B(b[2]), .Y(y[2]), .busy(busy[2]), .done(done[2]),
        .pass(pass[2]), .err_count(err[2]), .fail_mask(mask[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input int id, input logic [1:0] op, input bit stuck0);
        exp_t e;
        e    = '0;
        e.id = 2'(id);
        for (int i = 0; i < 4; i++) begin
            logic va, vb, yv, ev;
            va = i[1];
            vb = i[0];
            yv = stuck0 ? 1'b0 : (va | vb);
            case (op)
                2'b00:   ev = va & vb;
                2'b01:   ev = va | vb;
                2'b10:   ev = va ^ vb;
                default: ev = ~(va & vb);
            endcase
            if (yv != ev) begin
                e.mask[i] = 1'b1;
                e.err     = e.err + 3'd1;
            end
        end
        e.pass = (e.err == 3'd0);
        return e;
    endfunction

    task automatic check_all_zero(input string tag);
        for (int k = 0; k < 3; k++)
            check(tag, {a[k], b[k], busy[k], done[k], pass[k], err[k], mask[k]}, 0);
    endtask

    // One run on all three instances; poke re-pulses start with a new OP mid-run.
    task automatic run(input logic [1:0] op, input bit stuck0, input bit poke);
        int   done_cnt [3];
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            sb.push_back(model(k, op, stuck0));
            done_cnt[k] = 0;
        end
        @(negedge clk);
        op_in = op;
        tie0  = stuck0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            if (cyc == 1) check("busy_rise", busy[1], 1);
            if (cyc <= 12 && (cyc % 3) == 1)
                check("ab_step", {a[1], b[1]}, (cyc - 1) / 3);
            if (cyc == 13) check("ab_idle", {a[1], b[1]}, 0);
            for (int k = 0; k < 3; k++) begin
                if (done[k]) begin
                    done_cnt[k]++;
                    check("done_cycle", cyc, 4 * (settle_of[k] + 1) + 1);
                    check("busy_in_done", busy[k], 0);
                    if (sb.size() == 0) begin
                        check("sb_empty", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("sb_id", k, e.id);
                        check("pass", pass[k], e.pass);
                        check("err_count", err[k], e.err);
                        check("fail_mask", mask[k], e.mask);
                    end
                end
            end
            if (poke && cyc == 8) begin
                start = 1'b1;
                op_in = 2'b10;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        for (int k = 0; k < 3; k++) check("done_count", done_cnt[k], 1);
        check("sb_drained", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        #23;
        check_all_zero("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        run(2'b01, 1'b0, 1'b0);  // OR gate, OR expected
        run(2'b00, 1'b0, 1'b0);  // OR gate, AND expected
        run(2'b01, 1'b1, 1'b0);  // stuck-0, OR expected
        run(2'b11, 1'b1, 1'b0);  // stuck-0, NAND expected
        run(2'b11, 1'b0, 1'b1);  // OR gate vs NAND, start re-pulsed with XOR mid-run

        // Failing run, reset dropped during vector 2 of the default instance.
        @(negedge clk);
        op_in = 2'b01;
        tie0  = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        check("pre_rst_ab", {a[1], b[1]}, 2'b10);
        check("pre_rst_err", err[1], 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_all_zero("idle_after_reset");

        run(2'b01, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
